// File: rtl/unidade_controle_pkg.sv
// Shared constants for the multicycle controller: opcodes, FSM encodings, instruction fields.
// Optional flags feature is enabled with UNIDADE_CONTROLE_FLAGS_EN.
package unidade_controle_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;

   localparam logic [3:0] OP_MV  = 4'd0;
   localparam logic [3:0] OP_MVI = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] T1   = 2'd1;
   localparam logic [1:0] T2   = 2'd2;
   localparam logic [1:0] T3   = 2'd3;

   localparam int OP_LSB = 12;
   localparam int OP_W   = 4;
   localparam int RX_LSB = 9;
   localparam int RY_LSB = 6;

   function automatic logic is_valid_op(input logic [3:0] op);
      return (op <= OP_OR);
   endfunction

   // Only the arithmetic/logic group touches Z and C; moves leave them alone.
   function automatic logic sets_flags(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_OR);
   endfunction

endpackage

// File: rtl/unidade_controle_ula.sv
// Combinational ALU for the controller; carry/zero outputs exist only with UNIDADE_CONTROLE_FLAGS_EN.
module unidade_controle_ula
   import unidade_controle_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
`ifdef UNIDADE_CONTROLE_FLAGS_EN
   output logic              carry,
   output logic              zero,
`endif
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_MV:   result = b;
         OP_MVI:  result = a;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         default: result = '0;
      endcase
   end

`ifdef UNIDADE_CONTROLE_FLAGS_EN
   // An unsigned add overflowed exactly when the wrapped sum is below an operand.
   always_comb begin
      carry = 1'b0;
      case (op)
         OP_ADD:  carry = (result < a);
         OP_SUB:  carry = (a < b);
         default: carry = 1'b0;
      endcase
   end

   assign zero = (result == '0);
`endif

endmodule

// File: rtl/unidade_controle.sv
// Four-state multicycle controller driving an 8x16 register file through its read/write ports.
// Define UNIDADE_CONTROLE_FLAGS_EN to add registered Z and C flag outputs.
module unidade_controle
   import unidade_controle_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   input  logic [DATA_W-1:0] Data1,
   input  logic [DATA_W-1:0] Data2,
   output logic [ADDR_W-1:0] Read1,
   output logic [ADDR_W-1:0] Read2,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   output logic              Done,
`ifdef UNIDADE_CONTROLE_FLAGS_EN
   output logic              Z,
   output logic              C,
`endif
   output logic              Busy
);

   logic [1:0]        state;
   logic [OP_W-1:0]   op;
   logic [ADDR_W-1:0] rx;
   logic [ADDR_W-1:0] ry;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] g_reg;
   logic [DATA_W-1:0] alu_result;

`ifdef UNIDADE_CONTROLE_FLAGS_EN
   logic alu_carry;
   logic alu_zero;
   logic z_reg;
   logic c_reg;
`endif

   unidade_controle_ula #(.DATA_W(DATA_W)) ula (
      .op     (op),
      .a      (a_reg),
      .b      (b_reg),
`ifdef UNIDADE_CONTROLE_FLAGS_EN
      .carry  (alu_carry),
      .zero   (alu_zero),
`endif
      .result (alu_result)
   );

   // Only the used instruction fields are kept; bits [5:0] carry no meaning.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         op    <= '0;
         rx    <= '0;
         ry    <= '0;
         a_reg <= '0;
         b_reg <= '0;
         g_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Run) begin
                  op    <= DIN[OP_LSB +: OP_W];
                  rx    <= DIN[RX_LSB +: ADDR_W];
                  ry    <= DIN[RY_LSB +: ADDR_W];
                  state <= T1;
               end
            end
            T1: begin
               if (op == OP_MVI) begin
                  a_reg <= DIN;
               end else begin
                  a_reg <= Data1;
                  b_reg <= Data2;
               end
               state <= T2;
            end
            T2: begin
               if (is_valid_op(op)) begin
                  g_reg <= alu_result;
               end
               state <= T3;
            end
            T3:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UNIDADE_CONTROLE_FLAGS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         z_reg <= 1'b0;
         c_reg <= 1'b0;
      end else if ((state == T2) && sets_flags(op)) begin
         z_reg <= alu_zero;
         c_reg <= alu_carry;
      end
   end

   assign Z = z_reg;
   assign C = c_reg;
`endif

   // Strobes come straight from the state register so they cannot glitch on Run/DIN.
   assign Read1     = rx;
   assign Read2     = ry;
   assign WriteReg  = rx;
   assign WriteData = g_reg;
   assign Done      = (state == T3);
   assign RegWrite  = (state == T3) && is_valid_op(op);
   assign Busy      = (state != IDLE);

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle with a behavioural 8x16 register bank attached.
// Flag checks are compiled in when UNIDADE_CONTROLE_FLAGS_EN is defined.
module tb_unidade_controle;

   logic        clock = 1'b0;
   logic        reset;
   logic        Run;
   logic [15:0] DIN;
   logic [15:0] Data1;
   logic [15:0] Data2;
   logic [2:0]  Read1;
   logic [2:0]  Read2;
   logic [2:0]  WriteReg;
   logic [15:0] WriteData;
   logic        RegWrite;
   logic        Done;
   logic        Busy;
`ifdef UNIDADE_CONTROLE_FLAGS_EN
   logic        Z;
   logic        C;
`endif

   typedef struct {
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic        rw;
      logic        z;
      logic        c;
      int          cycle;
   } exp_t;

   exp_t        expQueue[$];
   int          checks = 0;
   int          errors = 0;
   int          cycleCount = 0;
   logic [15:0] bank [8] = '{default: 16'h0000};
   logic        loadEn = 1'b0;
   logic [2:0]  loadAddr = 3'd0;
   logic [15:0] loadData = 16'h0000;

   unidade_controle dut (
      .clock     (clock),
      .reset     (reset),
      .Run       (Run),
      .DIN       (DIN),
      .Data1     (Data1),
      .Data2     (Data2),
      .Read1     (Read1),
      .Read2     (Read2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .Done      (Done),
`ifdef UNIDADE_CONTROLE_FLAGS_EN
      .Z         (Z),
      .C         (C),
`endif
      .Busy      (Busy)
   );

   always #5 clock = ~clock;

   // Register bank model: DUT writes win over bench preloads.
   assign Data1 = bank[Read1];
   assign Data2 = bank[Read2];

   always @(posedge clock) begin
      cycleCount <= cycleCount + 1;
      if (RegWrite === 1'b1) bank[WriteReg] <= WriteData;
      else if (loadEn) bank[loadAddr] <= loadData;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Monitor: every retire pulse is matched against the oldest pending expectation.
   always @(negedge clock) begin
      exp_t e;
      if (Done === 1'b1) begin
         if (expQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone: got Done=1 at cycle %0d, expected no retire", cycleCount);
         end else begin
            e = expQueue.pop_front();
            checkOutput("WriteReg", {29'd0, WriteReg}, {29'd0, e.wreg});
            checkOutput("WriteData", {16'd0, WriteData}, {16'd0, e.wdata});
            checkOutput("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
            checkOutput("doneCycle", cycleCount, e.cycle);
`ifdef UNIDADE_CONTROLE_FLAGS_EN
            checkOutput("flagZ", {31'd0, Z}, {31'd0, e.z});
            checkOutput("flagC", {31'd0, C}, {31'd0, e.c});
`endif
         end
      end
   end

   task automatic pushExp(input logic [2:0] r, input logic [15:0] d, input logic rw,
                          input logic z, input logic c, input int cyc);
      exp_t e;
      e.wreg = r; e.wdata = d; e.rw = rw; e.z = z; e.c = c; e.cycle = cyc;
      expQueue.push_back(e);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (Busy !== 1'b0 && n < 20) begin
         @(posedge clock); #2;
         n++;
      end
      if (Busy !== 1'b0) begin
         checks++;
         errors++;
         $display("[TB] FAIL idleTimeout: got Busy=%b, expected 0 within 20 cycles", Busy);
      end
   endtask

   task automatic setReg(input logic [2:0] addr, input logic [15:0] data);
      @(posedge clock); #2;
      loadEn = 1'b1; loadAddr = addr; loadData = data;
      @(posedge clock); #2;
      loadEn = 1'b0;
   endtask

   // One instruction: Run for a single IDLE cycle, then the immediate during T1.
   task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] imm,
                                input logic [2:0] r, input logic [15:0] d, input logic rw,
                                input logic z, input logic c);
      waitIdle();
      @(posedge clock); #2;
      Run = 1'b1; DIN = instr;
      pushExp(r, d, rw, z, c, cycleCount + 3);
      @(posedge clock); #2;
      Run = 1'b0; DIN = imm;
      waitIdle();
   endtask

   initial begin
      int k;
      int n;
      reset = 1'b1; Run = 1'b0; DIN = 16'h0000;
      repeat (2) @(posedge clock);
      #2;
      checkOutput("resetBusy", {31'd0, Busy}, 32'd0);
      checkOutput("resetDone", {31'd0, Done}, 32'd0);
      checkOutput("resetRegWrite", {31'd0, RegWrite}, 32'd0);
      checkOutput("resetWriteData", {16'd0, WriteData}, 32'd0);
      checkOutput("resetRead1", {29'd0, Read1}, 32'd0);
      checkOutput("resetRead2", {29'd0, Read2}, 32'd0);
      checkOutput("resetWriteReg", {29'd0, WriteReg}, 32'd0);
`ifdef UNIDADE_CONTROLE_FLAGS_EN
      checkOutput("resetZ", {31'd0, Z}, 32'd0);
      checkOutput("resetC", {31'd0, C}, 32'd0);
`endif
      reset = 1'b0;

      applyStimulus(16'h1200, 16'h0005, 3'd1, 16'h0005, 1'b1, 1'b0, 1'b0);
      setReg(3'd2, 16'h0003);
      applyStimulus(16'h2280, 16'h0000, 3'd1, 16'h0008, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h3280, 16'h0000, 3'd1, 16'h0005, 1'b1, 1'b0, 1'b0);
      setReg(3'd1, 16'h0003);
      setReg(3'd2, 16'h0005);
      applyStimulus(16'h3280, 16'h0000, 3'd1, 16'hFFFE, 1'b1, 1'b0, 1'b1);
      setReg(3'd4, 16'hABCD);
      applyStimulus(16'h0900, 16'h0000, 3'd4, 16'hABCD, 1'b1, 1'b0, 1'b1);
      checkOutput("r4AfterMv", {16'd0, bank[4]}, 32'h0000ABCD);
      applyStimulus(16'hF000, 16'h0000, 3'd0, 16'hABCD, 1'b0, 1'b0, 1'b1);
      checkOutput("r0AfterInvalid", {16'd0, bank[0]}, 32'h00000000);

      // Abort an add in T2 with reset; nothing may retire.
      setReg(3'd1, 16'h0005);
      setReg(3'd2, 16'h0003);
      @(posedge clock); #2;
      Run = 1'b1; DIN = 16'h2280;
      @(posedge clock); #2;
      Run = 1'b0;
      @(posedge clock); #2;
      reset = 1'b1;
      @(posedge clock); #2;
      reset = 1'b0;
      checkOutput("abortBusy", {31'd0, Busy}, 32'd0);
      checkOutput("abortRegWrite", {31'd0, RegWrite}, 32'd0);
      checkOutput("abortDone", {31'd0, Done}, 32'd0);
      checkOutput("abortWriteData", {16'd0, WriteData}, 32'd0);
`ifdef UNIDADE_CONTROLE_FLAGS_EN
      checkOutput("abortZ", {31'd0, Z}, 32'd0);
      checkOutput("abortC", {31'd0, C}, 32'd0);
`endif
      repeat (4) @(posedge clock);
      #2;
      checkOutput("r1AfterAbort", {16'd0, bank[1]}, 32'h00000005);

      // Run held high: back-to-back adds, retires four cycles apart.
      waitIdle();
      @(posedge clock); #2;
      k = cycleCount;
      Run = 1'b1; DIN = 16'h2280;
      pushExp(3'd1, 16'h0008, 1'b1, 1'b0, 1'b0, k + 3);
      pushExp(3'd1, 16'h000B, 1'b1, 1'b0, 1'b0, k + 7);
      repeat (5) @(posedge clock);
      #2;
      Run = 1'b0;
      waitIdle();
      checkOutput("r1AfterHeld", {16'd0, bank[1]}, 32'h0000000B);

      // Run raised again during T1/T2 must not start another instruction.
      @(posedge clock); #2;
      k = cycleCount;
      Run = 1'b1; DIN = 16'h4280;
      pushExp(3'd1, 16'h0003, 1'b1, 1'b0, 1'b0, k + 3);
      @(posedge clock); #2;
      DIN = 16'h1200;
      @(posedge clock); #2;
      @(posedge clock); #2;
      Run = 1'b0;
      repeat (6) @(posedge clock);
      #2;
      checkOutput("busyAfterPulse", {31'd0, Busy}, 32'd0);
      checkOutput("queueAfterPulse", expQueue.size(), 32'd0);

      setReg(3'd1, 16'h00F0);
      setReg(3'd2, 16'h0F00);
      applyStimulus(16'h4280, 16'h0000, 3'd1, 16'h0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h0280, 16'h0000, 3'd1, 16'h0F00, 1'b1, 1'b1, 1'b0);

      n = 0;
      while (expQueue.size() != 0 && n < 20) begin
         @(posedge clock);
         n++;
      end
      #2;
      checkOutput("queueDrained", expQueue.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion by 200000, expected $finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
